trivium_stream_dec: RTL

//  Receive-side Trivium engine: loads 80-bit key and IV, runs the 1152-round warm-up,

---
 rtl/trivium_pkg.sv | 45 ++++
 rtl/trivium_rounds.sv | 38 +++
 rtl/trivium_stream_dec.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/trivium_pkg.sv
// Shared constants, FSM encoding and helpers for the Trivium stream decryptor.
package trivium_pkg;

   localparam int TRIV_STATE_W = 288;
   localparam int KEY_W        = 80;
   localparam int IV_W         = 80;
   localparam int INIT_RND     = 1152;

   // Output taps of the three shift-register sections (0-based state index)
   localparam int TAP_A_OUT = 65;
   localparam int TAP_A_FB  = 92;
   localparam int TAP_B_OUT = 161;
   localparam int TAP_B_FB  = 176;
   localparam int TAP_C_OUT = 242;
   localparam int TAP_C_FB  = 287;

   // Non-linear AND pairs and cross-section feed taps
   localparam int TAP_A_AND0 = 90;
   localparam int TAP_A_AND1 = 91;
   localparam int TAP_A_X    = 170;
   localparam int TAP_B_AND0 = 174;
   localparam int TAP_B_AND1 = 175;
   localparam int TAP_B_X    = 263;
   localparam int TAP_C_AND0 = 285;
   localparam int TAP_C_AND1 = 286;
   localparam int TAP_C_X    = 68;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      INIT   = 2'd1,
      STREAM = 2'd2
   } triv_fsm_t;

   // Reverse byte order of an 80-bit value: byte 0 (bits 79:72) lands in bits 7:0.
   // Bit order inside each byte is preserved.
   function automatic logic [79:0] byte_swap80(input logic [79:0] v);
      logic [79:0] r;
      r = '0;
      for (int i = 0; i < 10; i++) begin
         r[8*i +: 8] = v[79-8*i -: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/trivium_rounds.sv
// Combinational W-round unroll of the Trivium state update.
// Round k of the chain produces keystream bit o_ks[W-1-k], so the first
// keystream bit of the word ends up in the MSB.
module trivium_rounds #(
   parameter int W = 8
) (
   input  logic [287:0]  i_state,
   output logic [287:0]  o_state,
   output logic [W-1:0]  o_ks
);
   import trivium_pkg::*;

   logic [287:0] w_s;
   logic         w_t1;
   logic         w_t2;
   logic         w_t3;

   // Chain W rounds: each round emits one keystream bit and shifts all three sections
   always_comb begin
      w_s  = i_state;
      o_ks = '0;
      w_t1 = 1'b0;
      w_t2 = 1'b0;
      w_t3 = 1'b0;
      for (int k = 0; k < W; k++) begin
         w_t1 = w_s[TAP_A_OUT] ^ w_s[TAP_A_FB];
         w_t2 = w_s[TAP_B_OUT] ^ w_s[TAP_B_FB];
         w_t3 = w_s[TAP_C_OUT] ^ w_s[TAP_C_FB];
         o_ks[W-1-k] = w_t1 ^ w_t2 ^ w_t3;
         w_t1 = w_t1 ^ (w_s[TAP_A_AND0] & w_s[TAP_A_AND1]) ^ w_s[TAP_A_X];
         w_t2 = w_t2 ^ (w_s[TAP_B_AND0] & w_s[TAP_B_AND1]) ^ w_s[TAP_B_X];
         w_t3 = w_t3 ^ (w_s[TAP_C_AND0] & w_s[TAP_C_AND1]) ^ w_s[TAP_C_X];
         w_s  = {w_s[286:177], w_t2, w_s[175:93], w_t1, w_s[91:0], w_t3};
      end
      o_state = w_s;
   end

endmodule

// File: rtl/trivium_stream_dec.sv
// Receive-side Trivium engine: key/IV load, warm-up, then P = C xor keystream
// over a valid/ready word stream with a single output register stage.
module trivium_stream_dec #(
   parameter int W        = 8,
   parameter int INIT_RND = trivium_pkg::INIT_RND
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_en,
   input  logic [trivium_pkg::KEY_W-1:0] i_kin,
   input  logic                        i_krdy,
   output logic                        o_kvld,
   input  logic [trivium_pkg::IV_W-1:0]  i_ivin,
   input  logic                        i_ivrdy,
   output logic                        o_bsy,
   input  logic [W-1:0]                i_cin,
   input  logic                        i_cvalid,
   input  logic                        i_clast,
   output logic                        o_cready,
   output logic [W-1:0]                o_pout,
   output logic                        o_pvalid,
   output logic                        o_plast,
   input  logic                        i_pready
);
   import trivium_pkg::*;

   // Warm-up runs W rounds per step; the counter is one bit wider than needed
   // so it can sit at INIT_STEPS after the last step without wrapping.
   localparam int INIT_STEPS = INIT_RND / W;
   localparam int CNT_W      = $clog2(INIT_STEPS) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_STEPS - 1);

   triv_fsm_t                 r_fsm;
   triv_fsm_t                 w_fsm_next;
   logic [TRIV_STATE_W-1:0]   r_state;
   logic [KEY_W-1:0]          r_key;
   logic                      r_key_ok;
   logic                      r_kvld;
   logic                      r_bsy;
   logic [CNT_W-1:0]          r_cnt;
   logic [W-1:0]              r_pout;
   logic                      r_pvalid;
   logic                      r_plast;

   logic [TRIV_STATE_W-1:0]   w_next_state;
   logic [TRIV_STATE_W-1:0]   w_load_state;
   logic [W-1:0]              w_ks;
   logic                      w_key_cap;
   logic                      w_iv_cap;
   logic                      w_init_step;
   logic                      w_init_last;
   logic                      w_cready;
   logic                      w_xfer;
   logic                      w_drain;

   trivium_rounds #(
      .W (W)
   ) u_rounds (
      .i_state (r_state),
      .o_state (w_next_state),
      .o_ks    (w_ks)
   );

   // Initial state image: three ones on top, IV in the second section, key in the first
   assign w_load_state = {3'b111, 112'b0, byte_swap80(i_ivin), 13'b0, r_key};

   // Next-state logic and per-cycle strobes; nothing fires while i_en is low
   always_comb begin
      w_fsm_next  = r_fsm;
      w_key_cap   = 1'b0;
      w_iv_cap    = 1'b0;
      w_init_step = 1'b0;
      w_init_last = 1'b0;
      w_cready    = 1'b0;
      w_xfer      = 1'b0;
      w_drain     = 1'b0;
      unique case (r_fsm)
         IDLE: begin
            // Key strobe has priority; a new IV waits until the last word has drained
            w_key_cap = i_en & i_krdy;
            w_iv_cap  = i_en & i_ivrdy & r_key_ok & ~i_krdy & ~r_pvalid;
            if (w_iv_cap) begin
               w_fsm_next = INIT;
            end
         end
         INIT: begin
            w_init_step = i_en;
            w_init_last = i_en & (r_cnt == CNT_LAST);
            if (w_init_last) begin
               w_fsm_next = STREAM;
            end
         end
         STREAM: begin
            w_cready = i_en & (~r_pvalid | i_pready);
            w_xfer   = w_cready & i_cvalid;
            if (w_xfer && i_clast) begin
               w_fsm_next = IDLE;
            end
         end
         default: begin
            w_fsm_next = IDLE;
         end
      endcase
      w_drain = i_en & r_pvalid & i_pready & ~w_xfer;
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fsm <= IDLE;
      end else begin
         r_fsm <= w_fsm_next;
      end
   end

   // Cipher state: load on IV, advance during warm-up and only on accepted words
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= '0;
      end else if (w_iv_cap) begin
         r_state <= w_load_state;
      end else if (w_init_step || w_xfer) begin
         r_state <= w_next_state;
      end
   end

   // Key register and one-cycle capture pulse
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_key    <= '0;
         r_key_ok <= 1'b0;
         r_kvld   <= 1'b0;
      end else if (i_en) begin
         r_kvld <= w_key_cap;
         if (w_key_cap) begin
            r_key    <= byte_swap80(i_kin);
            r_key_ok <= 1'b1;
         end
      end
   end

   // Warm-up step counter and busy flag
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_bsy <= 1'b0;
      end else if (w_iv_cap) begin
         r_cnt <= '0;
         r_bsy <= 1'b1;
      end else if (w_init_step) begin
         r_cnt <= r_cnt + 1'b1;
         if (w_init_last) begin
            r_bsy <= 1'b0;
         end
      end
   end

   // Output register: fill on accepted word, empty on drain, hold while stalled
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pout   <= '0;
         r_pvalid <= 1'b0;
         r_plast  <= 1'b0;
      end else if (w_xfer) begin
         r_pout   <= i_cin ^ w_ks;
         r_pvalid <= 1'b1;
         r_plast  <= i_clast;
      end else if (w_drain) begin
         r_pvalid <= 1'b0;
      end
   end

   assign o_kvld   = r_kvld;
   assign o_bsy    = r_bsy;
   assign o_cready = w_cready;
   assign o_pout   = r_pout;
   assign o_pvalid = r_pvalid;
   assign o_plast  = r_plast;

endmodule
